// File: rtl/key_event_queue.sv
// Turns debounced key levels into single press events with optional hold auto-repeat,
// queues them in a small FIFO and presents them to the consumer over valid/ready.
module key_event_queue #(
  parameter int              NKEY       = 6,
  parameter int              FIFO_DEPTH = 4,
  parameter int              RPT_DELAY  = 50000000,
  parameter int              RPT_PERIOD = 10000000,
  parameter logic [NKEY-1:0] RPT_MASK   = {NKEY{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NKEY-1:0] key_lvl,
  output logic            evt_valid,
  output logic [2:0]      evt_code,
  input  logic            evt_ready,
  output logic [2:0]      evt_count,
  output logic            ovf
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int CW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  logic [NKEY-1:0] key_prev;
  logic [NKEY-1:0] pend;
  logic [2:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [1:0]      state;
  logic [CW-1:0]   cnt;

  logic [NKEY-1:0] rise;
  logic [NKEY-1:0] rpt;
  logic [NKEY-1:0] grant;
  logic [NKEY-1:0] pend_nxt;
  logic [NKEY-1:0] lost;
  logic            full;
  logic            push;
  logic            pop;
  logic [2:0]      push_code;
  logic [AW:0]     count_nxt;
  logic [AW-1:0]   rd_nxt;
  logic [2:0]      head_nxt;
  logic            changed;
  logic            onehot;
  logic [1:0]      state_nxt;
  logic [CW-1:0]   cnt_nxt;

  // Edge detection, lowest-index grant and pending-press bookkeeping
  always_comb begin
    rise      = key_lvl & ~key_prev;
    full      = (count == (AW + 1)'(FIFO_DEPTH));
    // pend & -pend isolates the lowest set bit, i.e. the lowest key code wins
    grant     = full ? {NKEY{1'b0}} : (pend & (~pend + NKEY'(1)));
    push      = |grant;
    push_code = 3'd0;
    for (int i = 0; i < NKEY; i++) begin
      push_code = push_code | (grant[i] ? 3'(i + 1) : 3'd0);
    end
    pend_nxt  = (pend | rise | rpt) & ~grant;
    lost      = (rise | rpt) & pend & ~grant;
  end

  // FIFO occupancy and the next head value so the outputs can be registered
  always_comb begin
    pop       = evt_valid & evt_ready;
    count_nxt = count + (AW + 1)'(push) - (AW + 1)'(pop);
    rd_nxt    = rd_ptr + AW'(pop);
    if (count_nxt == {(AW + 1){1'b0}}) begin
      head_nxt = 3'd0;
    end else if ((count == {(AW + 1){1'b0}}) || ((count == (AW + 1)'(1)) && pop)) begin
      head_nxt = push_code;
    end else begin
      head_nxt = mem[rd_nxt];
    end
  end

  // Auto-repeat sequencer: a single masked key held unchanged produces periodic presses
  always_comb begin
    changed   = (key_lvl != key_prev);
    onehot    = (key_lvl != {NKEY{1'b0}}) && ((key_lvl & (key_lvl - NKEY'(1))) == {NKEY{1'b0}});
    rpt       = {NKEY{1'b0}};
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (!changed && onehot && ((key_lvl & RPT_MASK) != {NKEY{1'b0}})) begin
          state_nxt = DELAY;
          cnt_nxt   = {CW{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      DELAY: begin
        if (changed) begin
          state_nxt = IDLE;
          cnt_nxt   = {CW{1'b0}};
        end else if (cnt == CW'(RPT_DELAY - 1)) begin
          rpt       = key_lvl;
          state_nxt = REPEAT;
          cnt_nxt   = {CW{1'b0}};
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (changed) begin
          state_nxt = IDLE;
          cnt_nxt   = {CW{1'b0}};
        end else if (cnt == CW'(RPT_PERIOD - 1)) begin
          rpt       = key_lvl;
          cnt_nxt   = {CW{1'b0}};
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // Control state; key_prev tracks the input even in reset so held keys stay silent
  always_ff @(posedge clk) begin
    key_prev <= key_lvl;
    if (rst) begin
      pend      <= {NKEY{1'b0}};
      wr_ptr    <= {AW{1'b0}};
      rd_ptr    <= {AW{1'b0}};
      count     <= {(AW + 1){1'b0}};
      state     <= IDLE;
      cnt       <= {CW{1'b0}};
      evt_valid <= 1'b0;
      evt_code  <= 3'd0;
      ovf       <= 1'b0;
    end else begin
      pend      <= pend_nxt;
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      evt_valid <= (count_nxt != {(AW + 1){1'b0}});
      evt_code  <= head_nxt;
      ovf       <= ovf | (|lost);
    end
  end

  // Event storage
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= push_code;
    end
  end

  assign evt_count = 3'(count);

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: expected codes are queued when presses
// are driven and compared when the consumer accepts an event.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] key_lvl;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;
  logic [2:0] evt_count;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  key_event_queue #(
    .NKEY(6), .FIFO_DEPTH(4), .RPT_DELAY(10), .RPT_PERIOD(4), .RPT_MASK(6'b000001)
  ) dut (
    .clk(clk), .rst(rst), .key_lvl(key_lvl), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ready(evt_ready), .evt_count(evt_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tap(input int k);
    key_lvl = 6'b000000;
    key_lvl[k] = 1'b1;
    tick();
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 40 && (evt_count != 3'd0 || evt_valid); i++) tick();
    check("drain_count", evt_count, 0);
    check("drain_valid", evt_valid, 0);
    evt_ready = 1'b0;
  endtask

  // Scoreboard: every accepted event must match the oldest expected code
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (sb.size() > 0) check("evt_code", evt_code, sb.pop_front());
      else check("unexpected_evt", evt_code, 0);
    end
  end

  initial begin
    int order4[5];
    int exp_v;
    rst = 1'b1; key_lvl = 6'b000000; evt_ready = 1'b0;
    tick(3);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_count", evt_count, 0);
    check("rst_ovf", ovf, 0);

    // single press, two-cycle latency
    rst = 1'b0; evt_ready = 1'b1; key_lvl = 6'b000100; sb.push_back(3);
    tick(); check("t1_valid_e1", evt_valid, 0);
    tick(); check("t1_valid_e2", evt_valid, 1); check("t1_code", evt_code, 3); check("t1_count", evt_count, 1);
    tick(); check("t1_count_after", evt_count, 0); check("t1_valid_after", evt_valid, 0);
    key_lvl = 6'b000000; tick(3);

    // simultaneous presses: lower code first
    key_lvl = 6'b100001; sb.push_back(1); sb.push_back(6);
    tick(); check("t2_valid_e1", evt_valid, 0);
    tick(); check("t2_code_a", evt_code, 1);
    tick(); check("t2_code_b", evt_code, 6);
    tick(); check("t2_valid_end", evt_valid, 0); check("t2_ovf", ovf, 0);
    key_lvl = 6'b000000; tick(3);

    // five presses into a four-entry FIFO with a stalled consumer
    evt_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sb.push_back(k + 1);
      tap(k);
    end
    key_lvl = 6'b000000; tick(4);
    check("t3_full", evt_count, 4); check("t3_head", evt_code, 2); check("t3_ovf", ovf, 0);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("t3_after_pop", evt_count, 3);
    tick(); check("t3_refill", evt_count, 4);
    drain();
    check("t3_ovf_end", ovf, 0);

    // second press of a key still pending sets the sticky overflow
    order4 = '{1, 3, 4, 5, 2};
    foreach (order4[i]) begin
      sb.push_back(order4[i] + 1);
      tap(order4[i]);
    end
    key_lvl = 6'b000000; tick(4);
    check("t4_full", evt_count, 4); check("t4_ovf_pre", ovf, 0);
    tap(2);
    key_lvl = 6'b000000; tick();
    check("t4_ovf_set", ovf, 1);
    tick(3);
    drain();
    check("t4_ovf_sticky", ovf, 1);

    // reset with a key held, then reset with queued events
    key_lvl = 6'b000100; rst = 1'b1; tick(2);
    check("t6_ovf_clr", ovf, 0); check("t6_count_rst", evt_count, 0);
    rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick(); check("t6_held_noevt", evt_valid, 0);
    end
    key_lvl = 6'b000000; tick(2);
    tap(1); tap(2); tap(3);
    key_lvl = 6'b000000; tick(4);
    check("t6_count3", evt_count, 3);
    rst = 1'b1; tick();
    check("t6_valid_rst", evt_valid, 0); check("t6_count_rst2", evt_count, 0); check("t6_code_rst", evt_code, 0);
    rst = 1'b0; tick(2);
    check("t6_discarded", evt_valid, 0);

    // auto-repeat on key 0: first event at +2, first repeat at +13, then every 4
    evt_ready = 1'b1; key_lvl = 6'b000001;
    for (int i = 0; i < 6; i++) sb.push_back(1);
    for (int n = 1; n <= 30; n++) begin
      tick();
      exp_v = (n == 2 || (n >= 13 && (n - 13) % 4 == 0)) ? 1 : 0;
      check("t5_rpt_valid", evt_valid, exp_v);
    end
    key_lvl = 6'b000000;
    for (int n = 1; n <= 12; n++) begin
      tick(); check("t5_released", evt_valid, 0);
    end

    // a second key mid-hold stops the repeats
    key_lvl = 6'b000001; sb.push_back(1); sb.push_back(1); sb.push_back(2);
    tick(14);
    key_lvl = 6'b000011;
    for (int n = 1; n <= 20; n++) begin
      tick(); check("t5_second_key", evt_valid, (n == 2) ? 1 : 0);
    end
    key_lvl = 6'b000000; tick(5);
    check("t5_ovf", ovf, 0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
